// File: rtl/conv33_window_sched_if.sv
// Handshake/bus bundle between the 3x3 window scheduler and its neighbours:
// the frame controller (start/abort/busy/done), the conv33 input stage
// (buf_load/buf_done) and the conv33 datapath (win_valid/win_ready and the
// window coordinates).
//   master : the scheduler side; drives busy, done, buf_load, win_valid,
//            win_row, win_col and win_cnt.
//   slave  : the environment side; drives start, abort, buf_done and win_ready.
interface conv33_window_sched_if;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        buf_load;
  logic        buf_done;
  logic        win_valid;
  logic        win_ready;
  logic [7:0]  win_row;
  logic [7:0]  win_col;
  logic [15:0] win_cnt;

  modport master (
    input  start, abort, buf_done, win_ready,
    output busy, done, buf_load, win_valid, win_row, win_col, win_cnt
  );

  modport slave (
    output start, abort, buf_done, win_ready,
    input  busy, done, buf_load, win_valid, win_row, win_col, win_cnt
  );
endinterface

// File: rtl/conv33_window_sched.sv
// 3x3 convolution window scheduler.
// Walks every valid 3x3 window of an IMG_W x IMG_H feature map in raster
// order (stride 1, no padding). For each window it requests a buffer load
// from the conv33 input stage, waits for the load to complete, then offers
// the window coordinates to the conv33 datapath until accepted.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   sif  : master modport of conv33_window_sched_if
//          (start/abort in, busy/done out, buf_load out/buf_done in,
//           win_valid out/win_ready in, win_row/win_col/win_cnt out)
module conv33_window_sched #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                        clk,
  input  logic                        rst,
  conv33_window_sched_if.master       sif
);

  // One-hot encoding: every Moore output is then a single state flop.
  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_LOAD  = 5'b00010;
  localparam logic [4:0] S_WAIT  = 5'b00100;
  localparam logic [4:0] S_ISSUE = 5'b01000;
  localparam logic [4:0] S_FIN   = 5'b10000;

  localparam logic [7:0] LAST_COL = 8'(IMG_W - 3);
  localparam logic [7:0] LAST_ROW = 8'(IMG_H - 3);

  logic [4:0]  state_q, state_d;
  logic [7:0]  row_q, row_d;
  logic [7:0]  col_q, col_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // abort in IDLE blocks a simultaneous start
        if (sif.start && !sif.abort) begin
          state_d = S_LOAD;
          row_d   = 8'd0;
          col_d   = 8'd0;
          cnt_d   = 16'd0;
        end
      end
      S_LOAD: begin
        state_d = sif.abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (sif.abort) begin
          state_d = S_IDLE;
        end else if (sif.buf_done) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (sif.abort) begin
          state_d = S_IDLE;
        end else if (sif.win_ready) begin
          cnt_d = cnt_q + 16'd1;
          if (col_q == LAST_COL && row_q == LAST_ROW) begin
            state_d = S_FIN;
          end else if (col_q == LAST_COL) begin
            col_d   = 8'd0;
            row_d   = row_q + 8'd1;
            state_d = S_LOAD;
          end else begin
            col_d   = col_q + 8'd1;
            state_d = S_LOAD;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= 8'd0;
      col_q   <= 8'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sif.busy      = ~state_q[0];
  assign sif.buf_load  = state_q[1];
  assign sif.win_valid = state_q[3];
  assign sif.done      = state_q[4];
  assign sif.win_row   = row_q;
  assign sif.win_col   = col_q;
  assign sif.win_cnt   = cnt_q;

endmodule
